// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a small FIFO, STATUS reads {overflow, full, busy}.
// Latency: a byte stored at edge n is popped at edge n+1 (tx falls then); each frame is 10*CLKS_PER_BIT cycles plus one idle cycle.
// Backpressure: none toward the core; a store to TXDATA while the FIFO is full is dropped and sets the sticky overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] rd,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic txdata_sel;
    logic status_sel;
    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic clr_ovf;

    // Exact 32-bit address decode; full is judged on the pre-edge count so a
    // push while full is dropped even if the FSM pops on the same edge.
    assign txdata_sel = (DataAdr == BASE_ADDR);
    assign status_sel = (DataAdr == STATUS_ADDR);
    assign full       = (count == DEPTH_C);
    assign push_req   = MemWriteM && txdata_sel;
    assign push       = push_req && !full;
    assign pop        = (state == IDLE) && (count != '0);
    assign clr_ovf    = MemWriteM && status_sel && WriteData[2];
    assign busy       = (state != IDLE) || (count != '0);

    // Status readback is purely address-driven, independent of the store strobe.
    always_comb begin
        rd = 32'b0;
        if (status_sel) begin
            rd = {29'b0, overflow, full, busy};
        end
    end

    // FIFO storage: data entries need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame serializer: start bit, 8 data bits LSB first, stop bit; tx is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (count != '0) begin
                        shift <= fifo_mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Frame timing is checked cycle-exactly against hand-derived edge numbers.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] STATUS = 32'hFFFF_0004;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] rd;
    logic        tx;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWriteM(MemWriteM),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .rd       (rd),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        MemWriteM = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        ticks(1);
        MemWriteM = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        DataAdr = STATUS;
        #1;
        v = rd;
        DataAdr = 32'h0;
    endtask

    // Waits for a start bit, then samples each bit at mid-cell; returns at stop mid-cell (f+38).
    task automatic rx_byte(input string tag, input logic [7:0] exp);
        int         waited = 0;
        logic [7:0] b = 8'h00;
        while (tx !== 1'b0 && waited < 300) begin
            ticks(1);
            waited++;
        end
        check({tag, "_start_seen"}, 32'(tx === 1'b0), 32'd1);
        if (tx === 1'b0) begin
            ticks(2);
            check({tag, "_start_mid"}, 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                ticks(4);
                b[i] = tx;
            end
            check({tag, "_data"}, 32'(b), 32'(exp));
            ticks(4);
            check({tag, "_stop_mid"}, 32'(tx), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] st;
        logic [9:0]  pat;
        int          n;
        int          low_cnt;
        int          busy_cnt;

        reset     = 1'b1;
        MemWriteM = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        ticks(2);
        reset = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        read_status(st);
        check("rst_status", st, 32'h0);

        // 1: single byte, upper WriteData bits ignored; frame 0,A5 lsb-first,1 at 4 cycles/bit
        pat = {1'b1, 8'hA5, 1'b0};
        write(BASE, 32'h1234_56A5);
        check("t1_tx_before_pop", 32'(tx), 32'd1);
        check("t1_busy_queued", 32'(busy), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            ticks(1);
            check($sformatf("t1_bit_cycle%0d", k), 32'(tx), 32'(pat[(k - 1) / 4]));
        end
        check("t1_busy_last_stop", 32'(busy), 32'd1);
        ticks(1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_tx_idle", 32'(tx), 32'd1);

        // 3: 0x00 then 0xFF; start bits 41 cycles apart
        write(BASE, 32'h00);
        write(BASE, 32'hFF);
        check("t3_first_start", 32'(tx), 32'd0);
        n = 0;
        while (tx === 1'b0 && n < 100) begin ticks(1); n++; end
        while (tx === 1'b1 && n < 100) begin ticks(1); n++; end
        check("t3_start_spacing", 32'(n), 32'd41);
        ticks(4);
        check("t3_ff_data", 32'(tx), 32'd1);
        ticks(35);
        check("t3_busy_end", 32'(busy), 32'd1);
        ticks(1);
        check("t3_busy_clear", 32'(busy), 32'd0);

        // 2a: five consecutive stores while idle; first pop frees a slot so all fit
        write(BASE, 32'h11);
        write(BASE, 32'h22);
        write(BASE, 32'h33);
        write(BASE, 32'h44);
        write(BASE, 32'h55);
        check("t2a_ovf", 32'(overflow), 32'd0);
        read_status(st);
        check("t2a_status_full", st, 32'h3);
        ticks(33);
        check("t2a_frame1_stop", 32'(tx), 32'd1);
        rx_byte("t2a_b22", 8'h22);
        rx_byte("t2a_b33", 8'h33);
        rx_byte("t2a_b44", 8'h44);
        rx_byte("t2a_b55", 8'h55);
        ticks(1);
        check("t2a_busy_tail", 32'(busy), 32'd1);
        ticks(1);
        check("t2a_busy_done", 32'(busy), 32'd0);

        // 2b: FSM mid-frame, FIFO fills to 4, fifth store dropped
        write(BASE, 32'h61);
        ticks(1);
        check("t2b_in_start", 32'(tx), 32'd0);
        write(BASE, 32'h62);
        write(BASE, 32'h63);
        write(BASE, 32'h64);
        write(BASE, 32'h65);
        check("t2b_ovf_before", 32'(overflow), 32'd0);
        write(BASE, 32'h66);
        check("t2b_ovf_set", 32'(overflow), 32'd1);
        read_status(st);
        check("t2b_status", st, 32'h7);
        ticks(32);
        check("t2b_frame1_stop", 32'(tx), 32'd1);
        rx_byte("t2b_b62", 8'h62);
        rx_byte("t2b_b63", 8'h63);
        rx_byte("t2b_b64", 8'h64);
        rx_byte("t2b_b65", 8'h65);
        ticks(2);
        check("t2b_only4_busy", 32'(busy), 32'd0);
        low_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            ticks(1);
            if (tx !== 1'b1) low_cnt++;
        end
        check("t2b_no_5th_frame", 32'(low_cnt), 32'd0);

        // 5: status readback with overflow set, then clear via bit 2
        read_status(st);
        check("t5_status_ovf_idle", st, 32'h4);
        write(STATUS, 32'hFFFF_FFFB);
        check("t5_ovf_kept", 32'(overflow), 32'd1);
        write(STATUS, 32'h4);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        read_status(st);
        check("t5_status_clear", st, 32'h0);

        // 4: stores to undecoded addresses have no effect
        MemWriteM = 1'b1;
        DataAdr   = 32'h0000_0064;
        WriteData = 32'hA5;
        #1;
        check("t4_rd_other", rd, 32'h0);
        ticks(1);
        MemWriteM = 1'b0;
        write(BASE + 32'd1, 32'hA5);
        busy_cnt = 0;
        low_cnt  = 0;
        for (int k = 0; k < 10; k++) begin
            ticks(1);
            if (busy !== 1'b0) busy_cnt++;
            if (tx !== 1'b1) low_cnt++;
        end
        check("t4_busy", 32'(busy_cnt), 32'd0);
        check("t4_tx", 32'(low_cnt), 32'd0);

        // 6: reset during data bit 3 with two bytes queued
        write(BASE, 32'h52);
        write(BASE, 32'h3C);
        write(BASE, 32'h77);
        ticks(16);
        check("t6_bit3_level", 32'(tx), 32'd0);
        read_status(st);
        check("t6_status_mid", st, 32'h1);
        reset = 1'b1;
        ticks(1);
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        busy_cnt = 0;
        low_cnt  = 0;
        for (int k = 0; k < 100; k++) begin
            ticks(1);
            if (busy !== 1'b0) busy_cnt++;
            if (tx !== 1'b1) low_cnt++;
        end
        check("t6_no_frames_tx", 32'(low_cnt), 32'd0);
        check("t6_no_frames_busy", 32'(busy_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the data-memory side of the pipelined core, in parallel with dmem.
- Consumes the same MemWriteM / DataAdr / WriteData signals that top exports.
- Buffers stored bytes in a small FIFO and serializes them as 8N1 frames on a single TX line.
- Drives a status word for loads from its status address.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte address of the TXDATA register. The STATUS register is at BASE_ADDR+4.
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal range is 2 or more.
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO. Must be a power of 2, 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  memory-stage store strobe.
- DataAdr  input  32  memory-stage byte address.
- WriteData  input  32  memory-stage store data.
- rd  output  32  status read data. Combinational.
- tx  output  1  serial line. Idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high, on the rising edge):
  - FIFO emptied: read and write pointers and count = 0.
  - state=IDLE, baud counter=0, bit index=0, shift register=0.
  - tx=1, overflow=0, busy=0.
  - Reset mid-frame aborts the frame. tx is 1 after that edge and the queued bytes are discarded.
- Register decode: exact 32-bit address compare. No other addresses are decoded.
- TXDATA push:
  - Condition: at a rising edge with MemWriteM=1 and DataAdr==BASE_ADDR.
  - If count<FIFO_DEPTH (sampled before the edge), WriteData[7:0] is written and count increments.
  - Otherwise the byte is dropped and overflow is set to 1.
  - WriteData[31:8] is ignored.
- STATUS write: MemWriteM=1, DataAdr==BASE_ADDR+4, WriteData[2]=1 clears overflow. Other bits are ignored.
- Overflow set and clear in the same cycle is impossible (different addresses).
- rd:
  - When DataAdr==BASE_ADDR+4: {29'b0, overflow, full, busy}, where full = (count==FIFO_DEPTH).
  - Otherwise rd = 32'b0.
  - Independent of MemWriteM.
- Simultaneous push and pop on one edge:
  - Both are performed and count is unchanged.
  - Full is judged on the pre-edge count, so a push while full is dropped even if a pop occurs on the same edge.
- Pointers wrap modulo FIFO_DEPTH.
- FSM (every state transition resets the baud counter to 0):
  - IDLE: tx=1. If count>0, pop the head byte into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment bit index. After bit 7 completes, go to STOP. Bits go out LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is a registered output, glitch-free.
- Latency:
  - A write sampled at edge n makes the FIFO non-empty after edge n.
  - The IDLE pop occurs at edge n+1, and tx falls after edge n+1.
  - One frame takes 10*CLKS_PER_BIT cycles.
  - Back-to-back queued bytes are separated by exactly one IDLE cycle, so the frame period is 10*CLKS_PER_BIT+1.
- busy = (state!=IDLE) || (count!=0). busy drops the cycle after the last STOP completes.

Test Plan:
1. CLKS_PER_BIT=4. Write 0xA5 to 0xFFFF0000 → tx falls one edge after the write. Over 40 cycles, tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. busy returns to 0 at cycle 41.
2. Write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles (FIFO_DEPTH=4):
   - The first pop occurs during the burst. Write 0x55 therefore fits, and overflow stays 0.
   - Repeat with the FSM held mid-frame and the FIFO already full. The 5th write is dropped, overflow=1, and only 4 frames are sent.
3. Two queued bytes 0x00 and 0xFF with CLKS_PER_BIT=4 → second start bit falls exactly 41 cycles after the first.
4. MemWriteM=1 with DataAdr=0x00000064 and WriteData=0xA5 → tx stays 1, busy stays 0, rd=0.
5. DataAdr=0xFFFF0004 after an overflow → rd=32'h5 or 32'h4 depending on busy. Then write WriteData=32'h4 to 0xFFFF0004 → overflow=0 and rd[2]=0.
6. Assert reset during DATA bit 3 of a frame with 2 bytes queued → after that edge tx=1, busy=0, overflow=0, and no further frames appear.
